lcd1602_arbiter: RTL and testbench

Write-only bus controller and two-port arbiter for an HD44780-compatible 16x2 character LCD.
- Two requesters (e.g. a text sequencer and a status writer) share the LCD pins.
- The block arbitrates round-robin, latches one command/data byte and drives the full RS/E write cycle with parameterised setup, pulse, hold and post-write execution wait, then acks.
- Sits between the application logic and the LCD pins, replacing free-running clock-divided enable generation.

---
 rtl/lcd1602_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_lcd1602_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_arbiter.sv
// lcd1602_arbiter
// Write-only bus controller and two-port round-robin arbiter for an
// HD44780-compatible 16x2 character LCD. One command/data byte is latched
// per grant, then driven through a full write cycle: setup, E pulse, hold,
// and an execution wait sized by the command. Completion is acked to the
// winning requester.
//
// Optional feature macro: LCD_INIT_EN
//   Defined   : after reset a power-up delay runs, then the init sequence
//               0x38, 0x0C, 0x06, 0x01 is written before ready rises.
//   Undefined : ready rises on the first clock edge after reset release.
//
// Ports
//   clk      system clock
//   reset    asynchronous, active-low reset
//   req      per-requester transfer request (bit i = requester i)
//   req_rs   per-requester RS (0 = command, 1 = data)
//   req_dat  per-requester byte, requester i in [8i+7:8i]
//   ack      one-cycle completion pulse, bit per requester
//   ready    init complete, requests accepted
//   busy     high whenever the engine is not idle
//   lcd_rs   LCD register select
//   lcd_rw   LCD read/write, always 0
//   lcd_en   LCD enable strobe
//   lcd_dat  LCD data bus
//
// Handshake: a requester raises req[i] with stable req_rs/req_dat and holds
// them until it sees ack[i]; it drops req[i] on the following cycle. A
// request still high in an idle cycle starts a new transfer.
module lcd1602_arbiter #(
    parameter int SETUP_CYCLES = 4,
    parameter int EN_CYCLES    = 12,
    parameter int HOLD_CYCLES  = 4,
    parameter int CMD_WAIT     = 2000,
    parameter int CLEAR_WAIT   = 82000,
    parameter int POWERUP_WAIT = 750000,
    parameter int CNT_W        = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_dat,
    output logic [1:0]  ack,
    output logic        ready,
    output logic        busy,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic [7:0]  lcd_dat
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
`ifdef LCD_INIT_EN
    localparam logic [2:0] S_PWRUP = 3'd5;
    localparam logic [2:0] S_INIT  = 3'd6;
`endif

    // Timer is loaded with N-1 on state entry and the state ends when it hits 0.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_WAIT - 1);
`ifdef LCD_INIT_EN
    localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(POWERUP_WAIT - 1);
`endif

    localparam int MAX_A   = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
    localparam int MAX_B   = (HOLD_CYCLES > CMD_WAIT) ? HOLD_CYCLES : CMD_WAIT;
    localparam int MAX_C   = (CLEAR_WAIT > POWERUP_WAIT) ? CLEAR_WAIT : POWERUP_WAIT;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam longint TIMER_SPAN = longint'(1) << CNT_W;

    if (longint'(MAX_CYC) > TIMER_SPAN) begin : g_bad_cnt_w
        $error("CNT_W too narrow for the largest cycle parameter");
    end

    logic [2:0]       state;
    logic [CNT_W-1:0] timer;
    logic             rr_pref;   // port favoured on the next tie
    logic             owner;     // port being served
    logic             ready_q;
    logic             rs_q;
    logic [7:0]       dat_q;
    logic             user_xfer; // current transfer belongs to a requester

`ifdef LCD_INIT_EN
    logic       user_q;
    logic [1:0] init_idx;
    logic [7:0] init_cmd;

    always_comb begin
        init_cmd = 8'h38;
        case (init_idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    end

    assign user_xfer = user_q;
`else
    assign user_xfer = 1'b1;
`endif

    logic             timer_zero;
    logic             any_req;
    logic             gnt;
    logic             is_clear;
    logic [CNT_W-1:0] wait_load;

    assign timer_zero = (timer == '0);
    assign any_req    = ready_q && (req != 2'b00);
    // On a tie the favoured port wins; otherwise the single requester wins.
    assign gnt        = (req == 2'b11) ? rr_pref : req[1];
    // Clear display / return home need the long execution time.
    assign is_clear   = !rs_q && (dat_q == 8'h01 || dat_q == 8'h02 || dat_q == 8'h03);
    assign wait_load  = is_clear ? CLEAR_LOAD : CMD_LOAD;

    assign busy    = (state != S_IDLE);
    assign lcd_en  = (state == S_PULSE);
    assign lcd_rw  = 1'b0;
    assign lcd_rs  = rs_q;
    assign lcd_dat = dat_q;
    assign ready   = ready_q;
    assign ack     = (state == S_WAIT && timer_zero && user_xfer)
                   ? (owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            rr_pref <= 1'b0;
            owner   <= 1'b0;
            ready_q <= 1'b0;
            rs_q    <= 1'b0;
            dat_q   <= 8'h00;
`ifdef LCD_INIT_EN
            user_q   <= 1'b0;
            init_idx <= 2'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
`ifdef LCD_INIT_EN
                    // ready is only low in idle straight after reset.
                    if (!ready_q) begin
                        state <= S_PWRUP;
                        timer <= PWRUP_LOAD;
                    end
`else
                    ready_q <= 1'b1;
`endif
                    if (any_req) begin
                        owner   <= gnt;
                        rr_pref <= ~gnt;
                        rs_q    <= gnt ? req_rs[1] : req_rs[0];
                        dat_q   <= gnt ? req_dat[15:8] : req_dat[7:0];
                        state   <= S_SETUP;
                        timer   <= SETUP_LOAD;
`ifdef LCD_INIT_EN
                        user_q  <= 1'b1;
`endif
                    end
                end
                S_SETUP: begin
                    if (timer_zero) begin
                        state <= S_PULSE;
                        timer <= EN_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (timer_zero) begin
                        state <= S_HOLD;
                        timer <= HOLD_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (timer_zero) begin
                        state <= S_WAIT;
                        timer <= wait_load;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (timer_zero) begin
`ifdef LCD_INIT_EN
                        if (!user_q) begin
                            if (init_idx == 2'd3) begin
                                state   <= S_IDLE;
                                ready_q <= 1'b1;
                            end else begin
                                state    <= S_INIT;
                                init_idx <= init_idx + 2'd1;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`ifdef LCD_INIT_EN
                S_PWRUP: begin
                    if (timer_zero) begin
                        state <= S_INIT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_INIT: begin
                    rs_q   <= 1'b0;
                    dat_q  <= init_cmd;
                    user_q <= 1'b0;
                    state  <= S_SETUP;
                    timer  <= SETUP_LOAD;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd1602_arbiter.sv
// Bench for lcd1602_arbiter: randomized and directed transfers, a high-level
// model of arbitration order and write-cycle timing feeding an expected queue,
// and a monitor that checks every ack against it.
module tb_lcd1602_arbiter;

    localparam int S   = 2;
    localparam int E   = 3;
    localparam int H   = 2;
    localparam int CW  = 5;
    localparam int CLW = 20;
    localparam int PW  = 10;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  req_rs;
    logic [15:0] req_dat;
    logic [1:0]  ack;
    logic        ready;
    logic        busy;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic [7:0]  lcd_dat;

    lcd1602_arbiter #(
        .SETUP_CYCLES(S), .EN_CYCLES(E), .HOLD_CYCLES(H),
        .CMD_WAIT(CW), .CLEAR_WAIT(CLW), .POWERUP_WAIT(PW), .CNT_W(20)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_rs(req_rs), .req_dat(req_dat),
        .ack(ack), .ready(ready), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en), .lcd_dat(lcd_dat)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (act=timeout req=finish)");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    // entry: [63:32] issue cycle (0 = unchecked), [31] back-to-back,
    //        [30] port, [29] rs, [23:16] byte, [15:0] ack offset from busy rise
    logic [63:0] exp_q[$];
    logic [7:0]  init_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          last_gnt = -1;   // port most recently granted, -1 after reset
    longint      cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_one(input int p, input logic [1:0] rs, input logic [15:0] dat,
                            input longint issue, input bit b2b);
        logic [7:0]  d;
        logic        r;
        int          w;
        logic [63:0] ent;
        d = dat[p*8 +: 8];
        r = rs[p];
        w = (r == 1'b0 && d >= 8'h01 && d <= 8'h03) ? CLW : CW;
        ent = {issue[31:0], b2b, p[0], r, 5'b0, d, 16'(S + E + H + w - 1)};
        exp_q.push_back(ent);
    endtask

    task automatic push_model(input logic [1:0] mask, input logic [1:0] rs,
                              input logic [15:0] dat, input longint issue);
        int first;
        if (mask == 2'b11) begin
            first = (last_gnt == 0) ? 1 : 0;
            push_one(first, rs, dat, issue, 1'b0);
            push_one(1 - first, rs, dat, 0, 1'b1);
            last_gnt = 1 - first;
        end else begin
            first = mask[1] ? 1 : 0;
            push_one(first, rs, dat, issue, 1'b0);
            last_gnt = first;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Hold each requested port until its ack, drop it the cycle after.
    task automatic serve(input logic [1:0] mask);
        logic [1:0] pending;
        logic [1:0] got;
        int n;
        pending = mask;
        n = 0;
        while (pending != 2'b00 && n < 3000) begin
            @(negedge clk);
            got = ack & pending;
            @(posedge clk);
            #1;
            req = req & ~got;
            pending = pending & ~got;
            n++;
        end
        if (pending != 2'b00) check("xfer_timeout", pending, 0);
    endtask

    // Called at posedge+1 with the DUT idle and ready.
    task automatic xfer(input logic [1:0] mask, input logic [1:0] rs,
                        input logic [15:0] dat, input bit withdraw);
        push_model(mask, rs, dat, cyc + 1);
        req_rs = rs;
        req_dat = dat;
        req = mask;
        if (withdraw) begin
            repeat (2) @(posedge clk);
            #1;
            req = 2'b00;
            req_dat = 16'hFFFF;
        end
        serve(mask);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_after_reset", ready, 1);
    endtask

`ifdef LCD_INIT_EN
    task automatic check_init();
        logic [7:0] seq [4];
        seq = '{8'h38, 8'h0C, 8'h06, 8'h01};
        check("init_count", init_q.size(), 4);
        for (int i = 0; i < 4 && i < init_q.size(); i++) check("init_cmd", init_q[i], seq[i]);
        init_q.delete();
    endtask
`endif

    // ---------------- monitor ----------------
    longint start_cyc = 0, fall_cyc = 0, en_start = 0, en_len = 0;
    logic   busy_p = 1'b0, en_p = 1'b0;
    logic [1:0] ack_p = 2'b00;
    logic [7:0] en_dat = 8'h00;
    logic       en_rs = 1'b0;

    always @(negedge clk) begin
        logic [63:0] ent;
        cyc++;
        if (!reset) begin
            busy_p = 1'b0;
            en_p = 1'b0;
            ack_p = 2'b00;
        end else begin
            if (ack_p != 2'b00) check("ack_one_cycle", ack, 0);
            if (!ready) begin
                if (lcd_en && !en_p) init_q.push_back(lcd_dat);
                if (ack != 2'b00) check("ack_before_ready", ack, 0);
            end else begin
                if (busy && !busy_p) start_cyc = cyc;
                if (!busy && busy_p) fall_cyc = cyc;
                if (lcd_en && !en_p) begin
                    en_start = cyc;
                    en_dat = lcd_dat;
                    en_rs = lcd_rs;
                end
                if (!lcd_en && en_p) en_len = cyc - en_start;
                if (ack != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", ack, 0);
                    end else begin
                        ent = exp_q.pop_front();
                        check("ack_port", ack, ent[30] ? 2'b10 : 2'b01);
                        check("lcd_rs", en_rs, ent[29]);
                        check("lcd_dat_at_en", en_dat, ent[23:16]);
                        check("lcd_dat_at_ack", lcd_dat, ent[23:16]);
                        check("en_offset", en_start - start_cyc, S);
                        check("en_width", en_len, E);
                        check("ack_time", cyc - start_cyc, ent[15:0]);
                        check("lcd_rw", lcd_rw, 0);
                        if (ent[63:32] != 0) check("grant_latency", start_cyc - ent[63:32], 1);
                        if (ent[31]) check("back_to_back", start_cyc - fall_cyc, 1);
                    end
                end
            end
            busy_p = busy;
            en_p = lcd_en;
            ack_p = ack;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  m;
        logic [1:0]  rs;
        logic [15:0] d;
        bit          wd;
        int          n;

        reset = 1'b0;
        req = 2'b00;
        req_rs = 2'b00;
        req_dat = 16'h0000;
        #12;
        check("rst_ack", ack, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_en", lcd_en, 0);
        check("rst_lcd_dat", lcd_dat, 0);

        // req[0] held from reset: never acked before ready, then served.
        push_model(2'b01, 2'b01, 16'h0041, 0);
        req_rs = 2'b01;
        req_dat = 16'h0041;
        req = 2'b01;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
`ifdef LCD_INIT_EN
        check("pwrup_ready", ready, 0);
        check("pwrup_busy", busy, 1);
`else
        check("ready_first_edge", ready, 1);
`endif
        serve(2'b01);
`ifdef LCD_INIT_EN
        check_init();
`endif

        // Directed cases.
        xfer(2'b01, 2'b01, 16'h0041, 1'b0);   // plain data write
        xfer(2'b11, 2'b11, 16'h3231, 1'b0);   // tie
        xfer(2'b11, 2'b11, 16'h3231, 1'b0);   // tie again
        xfer(2'b10, 2'b00, 16'h0100, 1'b0);   // clear display: long wait
        xfer(2'b10, 2'b00, 16'h0400, 1'b0);   // ordinary command
        xfer(2'b01, 2'b01, 16'h0041, 1'b1);   // withdrawn after grant

        // Randomized transfers.
        for (int i = 0; i < 30; i++) begin
            m = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) begin
                rs = 2'($urandom_range(0, 3)) & 2'b10;
                d = {8'($urandom_range(1, 4)), 8'($urandom_range(1, 4))};
            end else begin
                rs = 2'($urandom_range(0, 3));
                d = 16'($urandom);
            end
            wd = (m != 2'b11) && ($urandom_range(0, 3) == 0);
            xfer(m, rs, d, wd);
        end

        // Reset during the E pulse aborts the transfer.
        req_rs = 2'b01;
        req_dat = 16'h0055;
        req = 2'b01;
        n = 0;
        while (!lcd_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_pulse", lcd_en, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_lcd_en", lcd_en, 0);
        check("abort_busy", busy, 0);
        check("abort_ack", ack, 0);
        check("abort_ready", ready, 0);
        check("abort_lcd_dat", lcd_dat, 0);
        req = 2'b00;
        exp_q.delete();
        last_gnt = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_ready();
`ifdef LCD_INIT_EN
        check_init();
`endif
        xfer(2'b01, 2'b01, 16'h0041, 1'b0);
        xfer(2'b11, 2'b11, 16'h3231, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
